conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 The block SHALL have parameter ROW, default 32, meaning the number of systolic rows (feature inputs).
REQ-002 The block SHALL have parameter COL, default 32, meaning the number of systolic columns (filters).
REQ-003 The block SHALL have parameter LEN_W, default 16, meaning the width of the feature-length and stream counters.
REQ-004 The block SHALL have parameter DRAIN_LAT, default ROW+COL, meaning the array flush latency in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle request to run one convolution pass.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of the pass in progress.
REQ-009 The block SHALL have port weight_dim, input, 5 bits: kernel taps; legal range 1..ROW.
REQ-010 The block SHALL have port num_filter, input, 6 bits: number of active filters; legal range 1..COL.
REQ-011 The block SHALL have port feat_len, input, LEN_W bits: samples per row; legal range 1 or more.
REQ-012 The block SHALL have port weight_en, output, COL bits: per-column weight load enable.
REQ-013 The block SHALL have port w_idx, output, 5 bits: the weight tap index being loaded.
REQ-014 The block SHALL have port conv_ctrl, output, 1 bit: array mode, 0 = weight load, 1 = convolve.
REQ-015 The block SHALL have port t_cnt, output, LEN_W bits: the stream cycle counter; row r reads sample t_cnt-r.
REQ-016 The block SHALL have port row_vld, output, ROW bits: per-row feature-valid, skewed.
REQ-017 The block SHALL have port feat_zero, output, ROW bits: per-row force-zero (see REQ-036).
REQ-018 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until the end of DONE.
REQ-019 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the pass completes.
REQ-020 The block SHALL have port err, output, 1 bit: a one-cycle pulse when start is rejected for illegal configuration.

Function
REQ-021 The state machine SHALL have states IDLE, LOAD_W, GAP, STREAM, DRAIN and DONE.
REQ-022 In IDLE, a start with legal configuration SHALL capture weight_dim, num_filter and feat_len into registers and go to LOAD_W.
REQ-023 A start with illegal configuration (weight_dim 0 or >ROW, num_filter 0 or >COL, feat_len 0) SHALL pulse err for 1 cycle and remain in IDLE.
REQ-024 LOAD_W SHALL last exactly weight_dim cycles, with weight_en = (1<<num_filter)-1, w_idx counting 0..weight_dim-1, and conv_ctrl=0.
REQ-025 GAP SHALL last 1 cycle with weight_en=0 and conv_ctrl=0.
REQ-026 STREAM SHALL last feat_len+weight_dim-1 cycles, with conv_ctrl=1 and t_cnt counting from 0.
REQ-027 In STREAM, row_vld[r] SHALL be 1 iff r<weight_dim and r<=t_cnt<feat_len+r; in all other states row_vld SHALL be 0.
REQ-028 DRAIN SHALL last DRAIN_LAT cycles with conv_ctrl=1 and row_vld=0.
REQ-029 DONE SHALL last 1 cycle: done=1, then the machine returns to IDLE with conv_ctrl back at 0.
REQ-030 A start while busy SHALL be ignored, with no err pulse.
REQ-031 An abort in any non-IDLE state SHALL return the machine to IDLE on the next edge, with all outputs at reset values and no done pulse; abort SHALL take priority over start in the same cycle.
REQ-032 Counters SHALL saturate at their terminal values and never wrap within a pass.

Reset
REQ-033 While rst=1, the machine SHALL be asynchronously forced to IDLE, with weight_en, w_idx, conv_ctrl, t_cnt, row_vld, feat_zero, busy, done and err all at 0 and the captured configuration cleared.
REQ-034 A reset asserted mid-pass SHALL discard the pass, and no done SHALL follow.
REQ-035 After rst deasserts, the first cycle SHALL accept start.

Configuration
REQ-036 With CONV_SCHED_ZERO_PAD_EN defined, feat_zero[r] SHALL equal ~row_vld[r] during STREAM and DRAIN, and 0 otherwise; without the macro, feat_zero SHALL be tied to 0 and inactive rows carry don't-care data.

Structure
REQ-037 Package conv_sched_pkg SHALL hold the state enum, the default ROW/COL/LEN_W values, and the configuration-legality check function.
REQ-038 Sub-module conv_row_skew SHALL generate row_vld from t_cnt, weight_dim and feat_len.

Verification
REQ-039 Scenario: weight_dim=25, num_filter=2, feat_len=784 -> weight_en=0x3 for 25 cycles; STREAM 808 cycles; row_vld[0] for t 0..783; row_vld[24] for t 24..807; row_vld[31:25]=0; done 1+25+1+808+64 cycles after start.
REQ-040 Scenario: weight_dim=0 or num_filter=33 -> err pulse, busy stays 0, no weight_en.
REQ-041 Scenario: start re-pulsed at STREAM t=100 -> ignored; timing identical to the first scenario.
REQ-042 Scenario: abort at STREAM t=50 -> next cycle IDLE, conv_ctrl=0, row_vld=0, no done; a new start is accepted immediately.
REQ-043 Scenario: rst asserted in LOAD_W at w_idx=10 -> outputs go to 0 asynchronously, with no clock edge needed.
REQ-044 Scenario: weight_dim=1, feat_len=1, with ZERO_PAD on -> STREAM 1 cycle, row_vld=0x1, feat_zero=0xFFFFFFFE.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution scheduler.
// Default array geometry, FSM state encoding, and the start-time legality check.
// No logic of its own; imported by conv_sched and conv_row_skew.
package conv_sched_pkg;

  localparam int DEF_ROW   = 32;
  localparam int DEF_COL   = 32;
  localparam int DEF_LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // A pass is runnable only if every dimension is non-zero and fits the array.
  function automatic logic cfg_legal(input logic [4:0] wd, input logic [5:0] nf,
                                     input logic len_nz, input int row, input int col);
    return (wd != 5'd0) && (int'(wd) <= row) &&
           (nf != 6'd0) && (int'(nf) <= col) && len_nz;
  endfunction

endpackage

// File: rtl/conv_row_skew.sv
// Per-row feature-valid generator: row r is live for stream cycles r .. feat_len+r-1.
// Latency: purely combinational from the stream counter.
// No backpressure; rows at or beyond weight_dim are never valid.
module conv_row_skew
  import conv_sched_pkg::*;
#(
  parameter int ROW = DEF_ROW,
  parameter int CW  = DEF_LEN_W + 1
) (
  input  logic           active,
  input  logic [CW-1:0]  t_cnt,
  input  logic [4:0]     weight_dim,
  input  logic [CW-1:0]  feat_len,
  output logic [ROW-1:0] row_vld
);

  // Diagonal wavefront: each row sees the same feature window delayed by its index.
  always_comb begin
    row_vld = '0;
    for (int r = 0; r < ROW; r++) begin
      row_vld[r] = active && (r < int'(weight_dim)) &&
                   (t_cnt >= CW'(r)) && (t_cnt < feat_len + CW'(r));
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Systolic convolution pass scheduler: LOAD_W -> GAP -> STREAM -> DRAIN -> DONE.
// Latency: done arrives 1+weight_dim+1+(feat_len+weight_dim-1)+DRAIN_LAT cycles after start.
// No backpressure; start is ignored while busy, abort cancels next edge.
// Optional: CONV_SCHED_ZERO_PAD_EN drives feat_zero = ~row_vld during STREAM/DRAIN.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int ROW       = DEF_ROW,
  parameter int COL       = DEF_COL,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int DRAIN_LAT = ROW + COL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       weight_dim,
  input  logic [5:0]       num_filter,
  input  logic [LEN_W-1:0] feat_len,
  output logic [COL-1:0]   weight_en,
  output logic [4:0]       w_idx,
  output logic             conv_ctrl,
  output logic [LEN_W-1:0] t_cnt,
  output logic [ROW-1:0]   row_vld,
  output logic [ROW-1:0]   feat_zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so feat_len+weight_dim never overflows the stream count.
  localparam int CW = LEN_W + 1;

  state_t           state_q, state_d;
  logic [4:0]       wd_q;
  logic [5:0]       nf_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    cnt_q, cnt_term;
  logic             err_q, legal, accept, in_stream, in_conv;
  logic [ROW-1:0]   vld;

  assign legal     = cfg_legal(weight_dim, num_filter, feat_len != '0, ROW, COL);
  assign accept    = (state_q == S_IDLE) && start && !abort && legal;
  assign in_stream = (state_q == S_STREAM);
  assign in_conv   = (state_q == S_STREAM) || (state_q == S_DRAIN);

  // Last counter value of the current phase; the counter holds there.
  always_comb begin
    cnt_term = '0;
    case (state_q)
      S_LOAD_W: cnt_term = CW'(wd_q) - CW'(1);
      S_STREAM: cnt_term = {1'b0, len_q} + CW'(wd_q) - CW'(2);
      S_DRAIN:  cnt_term = CW'(DRAIN_LAT - 1);
      default:  cnt_term = '0;
    endcase
  end

  // Phase sequencing; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOAD_W;
      S_LOAD_W: if (cnt_q == cnt_term) state_d = S_GAP;
      S_GAP:    state_d = S_STREAM;
      S_STREAM: if (cnt_q == cnt_term) state_d = S_DRAIN;
      S_DRAIN:  if (cnt_q == cnt_term) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // State register and shared phase counter (cleared on every phase change, saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != cnt_term) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Configuration capture on accept; err flags a rejected start for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      nf_q  <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start && !abort && !legal;
      if (accept) begin
        wd_q  <= weight_dim;
        nf_q  <= num_filter;
        len_q <= feat_len;
      end
    end
  end

  conv_row_skew #(.ROW(ROW), .CW(CW)) u_skew (
    .active    (in_stream),
    .t_cnt     (cnt_q),
    .weight_dim(wd_q),
    .feat_len  ({1'b0, len_q}),
    .row_vld   (vld)
  );

  // Output decode purely from state so reset and abort clear them immediately.
  always_comb begin
    weight_en = '0;
    w_idx     = '0;
    conv_ctrl = in_conv;
    t_cnt     = '0;
    row_vld   = vld;
    feat_zero = '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    if (state_q == S_LOAD_W) begin
      for (int c = 0; c < COL; c++) weight_en[c] = (c < int'(nf_q));
      w_idx = cnt_q[4:0];
    end
    if (in_stream) t_cnt = cnt_q[LEN_W-1:0];
`ifdef CONV_SCHED_ZERO_PAD_EN
    if (in_conv) feat_zero = ~vld;
`else
    feat_zero = '0;
`endif
  end

  assign err = err_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with default geometry (32x32, LEN_W 16, drain 64).
// Stimulus changes and sampling both happen on the falling clock edge.
// Prints one summary line of passed/total checks.
module tb_conv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  weight_dim = '0;
  logic [5:0]  num_filter = '0;
  logic [15:0] feat_len = '0;
  logic [31:0] weight_en;
  logic [4:0]  w_idx;
  logic        conv_ctrl;
  logic [15:0] t_cnt;
  logic [31:0] row_vld;
  logic [31:0] feat_zero;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  // Results of the most recent run_pass.
  int          r_done_at, r_we, r_vld, r_cc, r_err;
  logic [31:0] r_we_val, r_fz;
  logic [4:0]  r_widx;
  logic [31:0] vld_at [0:1023];
  logic [31:0] fz_exp;
  int          found;

  conv_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .weight_dim(weight_dim), .num_filter(num_filter), .feat_len(feat_len),
    .weight_en(weight_en), .w_idx(w_idx), .conv_ctrl(conv_ctrl), .t_cnt(t_cnt),
    .row_vld(row_vld), .feat_zero(feat_zero), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue start at the current falling edge and watch the pass until done (bounded).
  task automatic run_pass(input logic [4:0] wd, input logic [5:0] nf,
                          input logic [15:0] len, input int restart_t);
    for (int k = 0; k < 1024; k++) vld_at[k] = '0;
    weight_dim = wd; num_filter = nf; feat_len = len; start = 1'b1;
    r_done_at = -1; r_we = 0; r_vld = 0; r_cc = 0; r_err = 0;
    r_we_val = '0; r_fz = '0; r_widx = '0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) check("busy_after_start", 64'(busy), 64'd1);
      if (weight_en != '0) begin r_we++; r_we_val = weight_en; r_widx = w_idx; end
      if (row_vld != '0) begin
        r_vld++;
        if (t_cnt < 16'd1024) vld_at[t_cnt] = row_vld;
        r_fz = feat_zero;
      end
      if (conv_ctrl) r_cc++;
      if (err) r_err++;
      if (restart_t >= 0 && row_vld != '0 && int'(t_cnt) == restart_t) start = 1'b1;
      if (done) begin r_done_at = i; break; end
    end
    @(negedge clk);
    check("post_done_conv_ctrl", 64'(conv_ctrl), 64'd0);
    check("post_done_busy", 64'(busy), 64'd0);
    check("post_done_done", 64'(done), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_weight_en", 64'(weight_en), 64'd0);
    check("rst_conv_ctrl", 64'(conv_ctrl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_row_vld", 64'(row_vld), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    rst = 1'b0;

    // Nominal 25-tap, 2-filter, 784-sample pass
    run_pass(5'd25, 6'd2, 16'd784, -1);
    check("p1_done_at", 64'(r_done_at), 64'd899);
    check("p1_we_cycles", 64'(r_we), 64'd25);
    check("p1_we_val", 64'(r_we_val), 64'h3);
    check("p1_widx_last", 64'(r_widx), 64'd24);
    check("p1_stream_cycles", 64'(r_vld), 64'd808);
    check("p1_conv_cycles", 64'(r_cc), 64'd872);
    check("p1_vld_t0", 64'(vld_at[0]), 64'h1);
    check("p1_vld_t24", 64'(vld_at[24]), 64'h01FF_FFFF);
    check("p1_vld_t783", 64'(vld_at[783]), 64'h01FF_FFFF);
    check("p1_vld_t784", 64'(vld_at[784]), 64'h01FF_FFFE);
    check("p1_vld_t807", 64'(vld_at[807]), 64'h0100_0000);

    // Same pass with a start re-pulsed mid-stream: must be ignored
    run_pass(5'd25, 6'd2, 16'd784, 100);
    check("p2_done_at", 64'(r_done_at), 64'd899);
    check("p2_stream_cycles", 64'(r_vld), 64'd808);
    check("p2_no_err", 64'(r_err), 64'd0);

    // Illegal configurations
    weight_dim = 5'd0; num_filter = 6'd2; feat_len = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ill_wd0_err", 64'(err), 64'd1);
    check("ill_wd0_busy", 64'(busy), 64'd0);
    check("ill_wd0_we", 64'(weight_en), 64'd0);
    @(negedge clk);
    check("ill_wd0_err_pulse", 64'(err), 64'd0);
    check("ill_wd0_busy2", 64'(busy), 64'd0);
    weight_dim = 5'd5; num_filter = 6'd33; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ill_nf33_err", 64'(err), 64'd1);
    check("ill_nf33_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("ill_nf33_we", 64'(weight_en), 64'd0);
    check("ill_nf33_err_pulse", 64'(err), 64'd0);

    // Abort at stream t=50, then immediate restart with a small pass
    weight_dim = 5'd25; num_filter = 6'd2; feat_len = 16'd784; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (conv_ctrl && row_vld != '0 && t_cnt == 16'd50) begin found = 1; break; end
      @(negedge clk);
    end
    check("abort_reach_t50", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_conv_ctrl", 64'(conv_ctrl), 64'd0);
    check("abort_row_vld", 64'(row_vld), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_no_done", 64'(done), 64'd0);
    run_pass(5'd3, 6'd4, 16'd5, -1);
    check("p3_done_at", 64'(r_done_at), 64'd76);
    check("p3_we_val", 64'(r_we_val), 64'hF);
    check("p3_we_cycles", 64'(r_we), 64'd3);
    check("p3_stream_cycles", 64'(r_vld), 64'd7);
    check("p3_vld_t2", 64'(vld_at[2]), 64'h7);
    check("p3_vld_t5", 64'(vld_at[5]), 64'h6);
    check("p3_vld_t6", 64'(vld_at[6]), 64'h4);

    // Asynchronous reset in LOAD_W at w_idx=10
    weight_dim = 5'd25; num_filter = 6'd2; feat_len = 16'd784; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (weight_en != '0 && w_idx == 5'd10) begin found = 1; break; end
      @(negedge clk);
    end
    check("rst_reach_widx10", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_weight_en", 64'(weight_en), 64'd0);
    check("arst_w_idx", 64'(w_idx), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // Start in the first cycle after reset release; minimal pass
    run_pass(5'd1, 6'd1, 16'd1, -1);
    check("p4_done_at", 64'(r_done_at), 64'd68);
    check("p4_stream_cycles", 64'(r_vld), 64'd1);
    check("p4_vld_t0", 64'(vld_at[0]), 64'h1);
`ifdef CONV_SCHED_ZERO_PAD_EN
    fz_exp = 32'hFFFF_FFFE;
`else
    fz_exp = 32'h0;
`endif
    check("p4_feat_zero", 64'(r_fz), 64'(fz_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
